intra_nbr_ctx: RTL

- Neighbour-context stage directly upstream of the 16x16 luma intra mode picker.
- Supplies top (16 px), left (16 px) and top_left samples for macroblock (x,y), following VP8 edge rules.
- Consumes the picker's chosen reconstruction (256 px) after each MB. Keeps the bottom row of every MB in a line RAM, and the right column plus the corner pixel in registers, for use by later MBs.

---
 rtl/intra_nbr_ctx_pkg.sv | 18 +
 rtl/intra_nbr_ctx_if.sv | 35 +++
 rtl/intra_nbr_ctx_nbr_line_ram.sv | 25 ++
 rtl/intra_nbr_ctx.sv | 106 ++++++++++
 4 files changed

// File: rtl/intra_nbr_ctx_pkg.sv
// intra_nbr_pkg: shared constants, one-hot FSM encoding and MB column helper for intra_nbr_ctx.
package intra_nbr_pkg;
   localparam int MB_SIZE = 16;
   localparam logic [7:0] TOP_EDGE_PX = 8'h7F;
   localparam logic [7:0] LEFT_EDGE_PX = 8'h81;
   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_RD   = 5'b00010,
      S_OUT  = 5'b00100,
      S_WR   = 5'b01000,
      S_PEND = 5'b10000
   } state_t;
   function automatic logic [8*MB_SIZE-1:0] mb_col(input logic [8*MB_SIZE*MB_SIZE-1:0] mb, input int c);
      logic [8*MB_SIZE-1:0] col;
      for (int r = 0; r < MB_SIZE; r++) col[8*r +: 8] = mb[8*(MB_SIZE*r+c) +: 8];
      return col;
   endfunction
endpackage

// File: rtl/intra_nbr_ctx_if.sv
// intra_nbr_ctx_if: control, neighbour and reconstruction bus of intra_nbr_ctx.
// top_right exists only when INTRA_NBR_TOPRIGHT_EN is defined.
interface intra_nbr_ctx_if;
   import intra_nbr_pkg::*;
   logic                           clear;
   logic [9:0]                     mb_w;
   logic                           fetch;
   logic [9:0]                     x;
   logic [9:0]                     y;
   logic [8*MB_SIZE-1:0]           top;
   logic [8*MB_SIZE-1:0]           left;
   logic [7:0]                     top_left;
   logic                           nbr_done;
   logic                           upd;
   logic [8*MB_SIZE*MB_SIZE-1:0]   rec;
   logic                           busy;
   logic                           err;
`ifdef INTRA_NBR_TOPRIGHT_EN
   logic [31:0]                    top_right;
`endif
   modport master (
      output clear, mb_w, fetch, x, y, upd, rec,
`ifdef INTRA_NBR_TOPRIGHT_EN
      input top_right,
`endif
      input top, left, top_left, nbr_done, busy, err
   );
   modport slave (
      input clear, mb_w, fetch, x, y, upd, rec,
`ifdef INTRA_NBR_TOPRIGHT_EN
      output top_right,
`endif
      output top, left, top_left, nbr_done, busy, err
   );
endinterface

// File: rtl/intra_nbr_ctx_nbr_line_ram.sv
// nbr_line_ram: MB bottom-row store, registered read-before-write; second read port with INTRA_NBR_TOPRIGHT_EN.
module nbr_line_ram #(
   parameter int DEPTH = 256,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [127:0]  wdata,
   input  logic [AW-1:0] raddr,
`ifdef INTRA_NBR_TOPRIGHT_EN
   input  logic [AW-1:0] raddr2,
   output logic [127:0]  rdata2,
`endif
   output logic [127:0]  rdata
);
   logic [127:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
`ifdef INTRA_NBR_TOPRIGHT_EN
      rdata2 <= mem[raddr2];
`endif
      if (we) mem[waddr] <= wdata;
   end
endmodule

// File: rtl/intra_nbr_ctx.sv
// intra_nbr_ctx: VP8 16x16 luma neighbour context (top/left/top_left) with line RAM and update path.
// Optional INTRA_NBR_TOPRIGHT_EN adds top_right from a second line RAM read.
module intra_nbr_ctx
   import intra_nbr_pkg::*;
#(
   parameter int MAX_MB_W = 256,
   parameter int AW = 8
) (
   input logic       clk,
   input logic       rst_n,
   intra_nbr_ctx_if.slave bus
);
   state_t st, st_nx;
   logic [9:0] xr, yr, px, py;
   logic [127:0] row_r, col_r, left_r, q;
   logic [7:0] corner;
   logic take_f, take_u, x_oor, oor, y0, commit, we;
   logic [AW-1:0] raddr;
   assign take_f = st == S_IDLE && bus.fetch && !bus.clear;
   assign take_u = st == S_IDLE && bus.upd && !bus.clear;
   assign x_oor = int'(bus.x) >= MAX_MB_W || bus.x >= bus.mb_w;
   assign oor = int'(xr) >= MAX_MB_W || xr >= bus.mb_w;
   assign y0 = yr == 0 || oor;
   assign commit = (st == S_WR || st == S_PEND) && !bus.clear;
   assign we = commit && !oor;
   // A pending fetch reads at the PEND edge; an update reads old RAM[xr] for the corner.
   assign raddr = st == S_PEND ? px[AW-1:0] : bus.upd ? xr[AW-1:0] : bus.x[AW-1:0];
   assign bus.nbr_done = st == S_OUT;
   assign bus.busy = st != S_IDLE;
   always_comb begin
      st_nx = S_IDLE;
      if (!bus.clear)
         case (st)
            S_IDLE:  st_nx = bus.upd ? (bus.fetch ? S_PEND : S_WR) : bus.fetch ? S_RD : S_IDLE;
            S_RD:    st_nx = S_OUT;
            S_PEND:  st_nx = S_RD;
            default: st_nx = S_IDLE;
         endcase
   end
`ifdef INTRA_NBR_TOPRIGHT_EN
   logic [127:0] q2;
   logic [AW-1:0] raddr2;
   assign raddr2 = raddr + AW'(1);
`endif
   nbr_line_ram #(.DEPTH(MAX_MB_W), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (xr[AW-1:0]),
      .wdata (row_r),
      .raddr (raddr),
`ifdef INTRA_NBR_TOPRIGHT_EN
      .raddr2(raddr2),
      .rdata2(q2),
`endif
      .rdata (q)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= S_IDLE;
         xr <= '0;
         yr <= '0;
         px <= '0;
         py <= '0;
         row_r <= '0;
         col_r <= '0;
         left_r <= '0;
         corner <= '0;
         bus.top <= '0;
         bus.left <= '0;
         bus.top_left <= '0;
         bus.err <= 1'b0;
`ifdef INTRA_NBR_TOPRIGHT_EN
         bus.top_right <= '0;
`endif
      end else begin
         st <= st_nx;
         bus.err <= !bus.clear && (bus.err || (take_f && x_oor));
         if (take_f && !bus.upd) begin
            xr <= bus.x;
            yr <= bus.y;
         end
         if (take_f && bus.upd) begin
            px <= bus.x;
            py <= bus.y;
         end
         if (take_u) begin
            row_r <= bus.rec[8*MB_SIZE*MB_SIZE-1 -: 8*MB_SIZE];
            col_r <= mb_col(bus.rec, MB_SIZE-1);
         end
         if (commit) left_r <= col_r;
         if (we) corner <= yr == 0 ? TOP_EDGE_PX : q[127:120];
         if (st == S_PEND && !bus.clear) begin
            xr <= px;
            yr <= py;
         end
         if (st == S_RD && !bus.clear) begin
            bus.top <= y0 ? {MB_SIZE{TOP_EDGE_PX}} : q;
            bus.left <= xr == 0 ? {MB_SIZE{LEFT_EDGE_PX}} : left_r;
            bus.top_left <= y0 ? TOP_EDGE_PX : xr == 0 ? LEFT_EDGE_PX : corner;
`ifdef INTRA_NBR_TOPRIGHT_EN
            bus.top_right <= y0 ? {4{TOP_EDGE_PX}} : xr == bus.mb_w - 10'd1 ? {4{q[127:120]}} : q2[31:0];
`endif
         end
      end
   end
endmodule
